// File: rtl/fgba_pkg.sv
// Shared definitions for the cartridge loader and its memory-side neighbours.
package fgba_pkg;

    // Loader control states.
    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StDone
    } loader_state_t;

    // Byte address of the first pak word and the size of the pak window in words.
    localparam logic [31:0] PAK_BASE  = 32'h0800_0000;
    localparam int unsigned PAK_WORDS = 1 << 23;

endpackage

// File: rtl/rom_loader_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words for the ROM loader.
module word_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic        flush_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    // Next-state: clear zeroes the word so a short final word is zero-padded.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = 2'd0;
            word_d = 32'h0;
        end else if (push_i) begin
            word_d[8*idx_q +: 8] = data_i;
            idx_d                = idx_q + 2'd1;
        end
    end

    // Byte index and packing register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= 2'd0;
            word_q <= 32'h0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
    // The word is complete on the fourth byte or on the image's last byte.
    assign full_o = push_i & ((idx_q == 2'd3) | flush_i);

endmodule

// File: rtl/rom_loader.sv
// Streams a length-prefixed cartridge image from a byte source into pak RAM.
module rom_loader
    import fgba_pkg::*;
#(
    parameter logic [31:0] MAX_BYTES = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        rpg,
    output logic [22:0] rpg_addr,
    output logic [31:0] rpg_data,
    output logic        rpg_write,
    output logic        busy,
    output logic        done,
    output logic        err
);

    loader_state_t state_q, state_d;

    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [23:0] len_q, len_d;         // low three header bytes, shifted in
    logic [31:0] remaining_q, remaining_d;
    logic [22:0] waddr_q, waddr_d;
    logic        err_q, err_d;

    logic rx_ready_q, rx_ready_d;
    logic rpg_q, rpg_d;
    logic rpg_write_q, rpg_write_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic        accept;
    logic [31:0] len_full;
    logic        wa_clear;
    logic        wa_push;
    logic        wa_flush;
    logic        wa_full;

    // rx_ready is registered and high exactly in LEN/DATA, so it qualifies transfers.
    assign accept   = rx_valid & rx_ready_q;
    assign len_full = {rx_data, len_q};

    // Fresh word on every entry into DATA (and on a new load).
    assign wa_clear = ((state_d == StData) && (state_q != StData)) ||
                      ((state_q == StIdle) && start);
    assign wa_push  = accept && (state_q == StData);
    assign wa_flush = (remaining_q == 32'd1);

    word_assembler u_word_assembler (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (wa_clear),
        .push_i  (wa_push),
        .flush_i (wa_flush),
        .data_i  (rx_data),
        .word_o  (rpg_data),
        .full_o  (wa_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                if (accept && (hdr_idx_q == 2'd3)) begin
                    if (len_full == 32'd0) begin
                        state_d = StDone;
                    end else if (len_full > MAX_BYTES) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (wa_full) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                state_d = (remaining_q == 32'd0) ? StDone : StData;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs follow the state being entered.
    always_comb begin
        rx_ready_d  = (state_d == StLen) || (state_d == StData);
        rpg_d       = (state_d == StLen) || (state_d == StData) || (state_d == StWrite);
        rpg_write_d = (state_d == StWrite);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
    end

    // Header capture, byte/word counters and the sticky error flag.
    always_comb begin
        hdr_idx_d   = hdr_idx_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        waddr_d     = waddr_q;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    hdr_idx_d   = 2'd0;
                    len_d       = 24'h0;
                    remaining_d = 32'd0;
                    waddr_d     = 23'd0;
                    err_d       = 1'b0;
                end
            end
            StLen: begin
                if (accept) begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    len_d     = {rx_data, len_q[23:8]};
                    if (hdr_idx_q == 2'd3) begin
                        if (len_full > MAX_BYTES) begin
                            err_d = 1'b1;
                        end else begin
                            remaining_d = len_full;
                        end
                    end
                end
            end
            StData: begin
                if (accept) begin
                    remaining_d = remaining_q - 32'd1;
                end
            end
            StWrite: begin
                // MAX_BYTES bounds the word count, so this never wraps mid-image.
                waddr_d = waddr_q + 23'd1;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_idx_q   <= 2'd0;
            len_q       <= 24'h0;
            remaining_q <= 32'd0;
            waddr_q     <= 23'd0;
            err_q       <= 1'b0;
            rx_ready_q  <= 1'b0;
            rpg_q       <= 1'b0;
            rpg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            hdr_idx_q   <= hdr_idx_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            waddr_q     <= waddr_d;
            err_q       <= err_d;
            rx_ready_q  <= rx_ready_d;
            rpg_q       <= rpg_d;
            rpg_write_q <= rpg_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign rpg       = rpg_q;
    assign rpg_addr  = waddr_q;
    assign rpg_write = rpg_write_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: image model plus directed loads.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rpg;
    logic [22:0] rpg_addr;
    logic [31:0] rpg_data;
    logic        rpg_write;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    rom_loader #(
        .MAX_BYTES (32'h0200_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rpg       (rpg),
        .rpg_addr  (rpg_addr),
        .rpg_data  (rpg_data),
        .rpg_write (rpg_write),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [22:0] addr;
        logic [31:0] data;
    } wr_t;

    int   n_pass  = 0;
    int   n_total = 0;
    int   n_writes = 0;
    int   n_done   = 0;
    bit   gappy    = 1'b0;
    wr_t  exp_q[$];
    wr_t  log_q[$];
    wr_t  mon_e;
    logic [7:0] img[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: words of the image, little-endian, zero-padded, from address 0.
    task automatic expect_image(input int nbytes);
        wr_t w;
        for (int i = 0; i < (nbytes + 3) / 4; i++) begin
            w.addr = 23'(i);
            w.data = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * i + b < nbytes) w.data[8*b +: 8] = img[4*i + b];
            end
            exp_q.push_back(w);
        end
    endtask

    // Every write strobe is checked against the model.
    always @(negedge clk) begin
        if (rpg_write) begin
            mon_e.addr = rpg_addr;
            mon_e.data = rpg_data;
            log_q.push_back(mon_e);
            n_writes++;
            chk("write_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", rpg_addr, mon_e.addr);
                chk("wr_data", rpg_data, mon_e.data);
            end
            chk("write_rx_ready_low", rx_ready, 0);
            chk("write_rpg_high", rpg, 1);
        end
        if (done) begin
            n_done++;
            chk("done_rpg_low", rpg, 0);
        end
    end

    // All tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        if (gappy) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (!rx_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_ready) chk("rx_ready_timeout", rx_ready, 1);
        else @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] len);
        for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8]);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rpg_after_start", rpg, 1);
        chk("busy_after_start", busy, 1);
        chk("rx_ready_in_len", rx_ready, 1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("rpg_low_after_done", rpg, 0);
        chk("done_one_cycle", done, 0);
        chk("busy_low_after_done", busy, 0);
    endtask

    task automatic run_load(input int nbytes);
        int w0, d0, lat;
        w0 = n_writes;
        d0 = n_done;
        expect_image(nbytes);
        do_start();
        send_header(32'(nbytes));
        for (int i = 0; i < nbytes; i++) send_byte(img[i]);
        wait_done(lat);
        chk("done_latency", lat, (nbytes == 0) ? 0 : 1);
        chk("write_count", n_writes - w0, (nbytes + 3) / 4);
        chk("done_count", n_done - d0, 1);
        chk("model_drained", exp_q.size(), 0);
        chk("err_clear", err, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin : main
        int base, w0, d0;
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h0;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_rpg", rpg, 0);
        chk("rst_rpg_addr", rpg_addr, 0);
        chk("rst_rpg_data", rpg_data, 0);
        chk("rst_rpg_write", rpg_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // 8-byte image.
        img  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        base = log_q.size();
        run_load(8);
        chk("img8_w0_addr", log_q[base].addr, 23'd0);
        chk("img8_w0_data", log_q[base].data, 32'h4433_2211);
        chk("img8_w1_addr", log_q[base+1].addr, 23'd1);
        chk("img8_w1_data", log_q[base+1].data, 32'h8877_6655);

        // Partial final word.
        img  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        base = log_q.size();
        run_load(5);
        chk("img5_w1_addr", log_q[base+1].addr, 23'd1);
        chk("img5_w1_data", log_q[base+1].data, 32'h0000_0055);

        // Empty image: done right after the fourth header byte.
        img.delete();
        run_load(0);

        // Oversize header.
        w0 = n_writes;
        d0 = n_done;
        do_start();
        send_header(32'h0200_0001);
        chk("ovs_err", err, 1);
        chk("ovs_rpg", rpg, 0);
        chk("ovs_busy", busy, 0);
        @(negedge clk);
        chk("ovs_err_sticky", err, 1);
        chk("ovs_writes", n_writes - w0, 0);
        chk("ovs_no_done", n_done - d0, 0);
        do_start();
        chk("ovs_err_cleared", err, 0);
        send_header(32'h0);
        wait_done(base);

        // Gappy source with an odd length.
        gappy = 1'b1;
        img.delete();
        for (int i = 0; i < 23; i++) img.push_back(8'($urandom_range(0, 255)));
        run_load(23);
        gappy = 1'b0;

        // Reset after two words of a 16-byte load.
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'(8'hA0 + i));
        w0 = n_writes;
        expect_image(16);
        do_start();
        send_header(32'd16);
        for (int i = 0; i < 8; i++) send_byte(img[i]);
        @(negedge clk);
        chk("rst_mid_writes", n_writes - w0, 2);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rx_ready", rx_ready, 0);
        chk("mid_rst_rpg", rpg, 0);
        chk("mid_rst_rpg_write", rpg_write, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", rpg_addr, 0);
        chk("mid_rst_data", rpg_data, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        img  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        base = log_q.size();
        run_load(8);
        chk("restart_addr0", log_q[base].addr, 23'd0);
        chk("restart_data0", log_q[base].data, 32'hEFBE_ADDE);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Streams a cartridge image from a byte source (UART receiver) into pak RAM through the memory block's `rpg` loader port. It holds `rpg` high for the whole load, which stalls the CPU because `ok` is low. It parses a 4-byte little-endian length header, packs payload bytes into 32-bit little-endian words and issues one `rpg_write` per word at consecutive word addresses starting at 0 (byte 0x08000000). It sits between the byte receiver and `memory`.

## Interface
- `MAX_BYTES`, default 32'h0200_0000: largest accepted image in bytes (the 32 MiB pak window, 2^23 words).
- `clk`  in  1: system clock; the same clock as `memory.clk`.
- `rst`  in  1: reset, synchronous and active-high; one clock only.
- `start`  in  1: one-cycle pulse that begins a load; ignored unless in IDLE.
- `rx_data`  in  8: incoming byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader accepts a byte. A byte transfers on a rising edge with `rx_valid & rx_ready`.
- `rpg`  out  1: loader owns the memory port.
- `rpg_addr`  out  23: word address into the pak region.
- `rpg_data`  out  32: word to write.
- `rpg_write`  out  1: write strobe, exactly one cycle per word.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on successful completion.
- `err`  out  1: sticky oversize-header flag; cleared by `start` or `rst`.

## Operation
- All outputs are registered.
- Reset value of every output is 0, and the FSM goes to IDLE.
- States: IDLE, LEN, DATA, WRITE, DONE.
- **IDLE:**
  - `rx_ready`=0, `rpg`=0.
  - On `start`: clear `err`, byte counter, word address and packing index; go to LEN with `rpg`=1.
- **LEN:**
  - `rx_ready`=1.
  - Accepted byte k (0..3) goes to `len[8k+7:8k]`.
  - After byte 3:
    - `len`==0 → DONE.
    - `len`>`MAX_BYTES` → set `err`, drop `rpg`, go to IDLE with no `done` pulse.
    - Otherwise `remaining`=`len`, go to DATA.
- **DATA:**
  - `rx_ready`=1.
  - Accepted byte i (0..3) goes to `word[8i+7:8i]`; `remaining` decrements per byte.
  - Go to WRITE when i==3 is accepted, or when `remaining` reaches 0.
  - On a partial final word, unfilled bytes are 0.
  - The word register is cleared at entry to each word.
- **WRITE:**
  - `rx_ready`=0.
  - `rpg_write`=1 for exactly one cycle, with `rpg_data`=assembled word and `rpg_addr`=current word address.
  - Next cycle: word address +1. If `remaining`==0 go to DONE, else go to DATA.
- **DONE:** `done`=1 for one cycle, `rpg`=0, then IDLE.
- **Address wrap:** cannot occur. The `MAX_BYTES` check bounds the word count to 2^23.
- **`start` while busy:** ignored.
- **`rst` mid-load:** aborts at the next edge.
  - `rpg` and `rpg_write` go low and the FSM returns to IDLE.
  - Words already written stay in pak RAM.
  - The next `start` restarts at address 0.
- **`rx_valid` low:** the FSM waits in LEN/DATA indefinitely. There is no timeout.

## Timing
- `rpg` rises on the edge after the `start` pulse and stays high until the DONE cycle or the error exit.
- WRITE is one cycle because `memory` treats `rpg` writes as aligned 32-bit and commits them on the same `clk` edge.
- `rpg_addr`/`rpg_data` are stable during the whole WRITE cycle.
- Throughput: 4 byte cycles + 1 WRITE cycle per full word, so at most 4 bytes per 5 clocks. Sources must tolerate `rx_ready` dropping for 1 cycle per word.
- `done` occurs 1 cycle after the last WRITE, or 1 cycle after the 4th header byte when `len`==0.
- `err` is set on the edge that accepts header byte 3.

## Structure
- Shared package `fgba_pkg`:
  - State enum `loader_state_t` (IDLE, LEN, DATA, WRITE, DONE).
  - Constant `PAK_BASE` = 32'h0800_0000.
  - Constant `PAK_WORDS` = 2^23.
- Sub-module `word_assembler`:
  - Contains the byte index, the 32-bit shift-in register, and clear/full/flush controls.
  - The FSM and counters stay in `rom_loader`.

## Test plan
- **8-byte image:** header 08 00 00 00, then 11 22 33 44 55 66 77 88 → writes addr 0 = 0x44332211, addr 1 = 0x88776655. `done` pulses once. `rpg` is low the cycle after `done`.
- **Partial final word:** header 05 00 00 00, then 11 22 33 44 55 → addr 1 = 0x00000055. Exactly 2 `rpg_write` pulses.
- **Empty image:** header 00 00 00 00 → `done` 1 cycle after the 4th byte. Zero writes.
- **Oversize header:** header 01 00 00 02 (0x02000001) → `err`=1, no writes, `rpg` low, no `done`. A following `start` clears `err`.
- **Gappy source:** `rx_valid` toggled randomly → `rx_ready`=0 in every WRITE cycle, no byte lost or duplicated, data matches the reference image.
- **Reset mid-load:** `rst` after 2 words of a 16-byte load → all outputs 0 the next cycle. A new `start` writes from addr 0 again.
